sram_line_fetch: RTL and testbench
==================================

// Module: sram_line_fetch
// PURPOSE
// - Upstream feeder of the frame buffer: streams background palette indices (pixelIn) from SRAM, one per pixel strobe.
// - SRAM word = 3 packed 5-bit pixels: [4:0] first, [9:5] second, [14:10] third; [15] ignored.
// - Applies horizontal scroll offset, updated once per frame.
// - Fetches only when the frame buffer grants the bus (SRAM_Read); 5'h15 = transparent, frame buffer keeps old pixel.
// PARAMETERS
// - MAP_WORDS   213  words per map row (map width = 3*MAP_WORDS px); scroll wraps here
// - SCROLL_STEP 1    px added to scroll per enabled frame; legal 1..2
// - BASE_ADDR   0    SRAM word address of map row 0
// PORTS
// - Clk           in   1   system clock (50 MHz)
// - Reset_n       in   1   async reset, active low
// - frame_start   in   1   1-cycle pulse, start of vertical blank
// - line_start    in   1   1-cycle pulse, >=8 Clk before first pixel_adv of a line
// - pixel_adv     in   1   1-cycle strobe per displayed pixel; never in consecutive cycles
// - DrawY         in   10  row of the line being fetched; sampled on line_start
// - gameState     in   2   00 START, 01 PLAY, 10 GAMEOVER
// - ScrollEnable  in   1   sampled on frame_start
// - SRAM_Read     in   1   bus grant from frame buffer
// - SRAM_DQ       in   16  SRAM read data, valid the cycle after address issued
// - SRAM_ADDR     out  20  word address; reset 0
// - SRAM_CE_N     out  1   chip enable, low while a read is issued; reset 1
// - SRAM_OE_N     out  1   output enable, equals SRAM_CE_N; reset 1
// - pixelIn       out  5   pixel to frame buffer; reset 5'h15
// - underflow     out  1   sticky: pixel needed but word not ready; cleared on frame_start; reset 0
// BEHAVIOUR
// - Scroll: regs scroll_word (0..MAP_WORDS-1), scroll_sub (0..2); reset 0/0.
//   On frame_start with gameState==PLAY and ScrollEnable: sub+=SCROLL_STEP; if sub>=3 then sub-=3, word+1 (wrap to 0 at MAP_WORDS).
// - Row base: row_addr = BASE_ADDR + DrawY*MAP_WORDS, registered on line_start (1-cycle latency; no divides).
// - Pointers: rd_word = scroll_word, cur_sub = scroll_sub, both loaded on line_start.
// - FSM:
//   - IDLE: on line_start with gameState==PLAY -> PRIME; otherwise stay, pixelIn=5'h15.
//   - PRIME: issue reads when SRAM_Read=1 until cur and next word regs both valid -> STREAM.
//   - STREAM: pixelIn = field cur_sub of cur word.
//     - On pixel_adv: cur_sub++. When cur_sub was 2: cur_sub=0, cur<=next, next invalid.
//     - Refetch whenever next invalid, no read outstanding, and SRAM_Read=1.
//   - Any state: frame_start or gameState!=PLAY -> IDLE, outstanding read data discarded; line_start restarts PRIME.
// - Read issue (one cycle): SRAM_ADDR = row_addr + rd_word; CE_N=OE_N=0 only while SRAM_Read=1.
//   Data captured next cycle; rd_word increments, wraps MAP_WORDS-1 -> 0 (seamless horizontal map wrap).
// - Underflow: pixel_adv at word boundary with next invalid:
//   - pixelIn=5'h15 until the word arrives, then resume at sub 0 of that word.
//   - underflow set; the lost pixel is not replayed.
// - pixel_adv during IDLE/PRIME: ignored; pixelIn stays 5'h15.
// - Simultaneous frame_start+line_start: frame_start (scroll update) first, then line loads the new scroll values.
// - Reset_n low mid-read: all regs to reset values immediately; SRAM_CE_N=1 asynchronously.
// TESTING
// - PLAY, scroll 0/0, DrawY=0, words 0x7FE0/0x0421, grant always -> pixelIn 00,1F,1F,01,01,01.
// - scroll_sub=2 at line start -> first pixel is word0[14:10], next from word1[4:0].
// - scroll_word=MAP_WORDS-1 -> 2nd word read at row_addr+0; 3 frame_starts, STEP=1, from 0/2 -> 1/2 (one carry).
// - SRAM_Read held low 20 cycles across a word boundary -> pixelIn=5'h15, underflow=1; next frame_start clears it.
// - gameState=START -> SRAM_CE_N stays 1, pixelIn=5'h15; scroll unchanged by frame_start.
// - Reset_n low during STREAM with read outstanding -> CE_N=1, pixelIn=5'h15 same cycle; IDLE after release.

Source files
------------

// File: rtl/sram_line_fetch.sv
// Background line fetcher: streams 5-bit palette indices out of packed SRAM words
// (three pixels per word), with per-frame horizontal scroll and a two-word prefetch buffer.
module sram_line_fetch #(
  parameter int MAP_WORDS   = 213,
  parameter int SCROLL_STEP = 1,
  parameter int BASE_ADDR   = 0
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        frame_start,
  input  logic        line_start,
  input  logic        pixel_adv,
  input  logic [9:0]  DrawY,
  input  logic [1:0]  gameState,
  input  logic        ScrollEnable,
  input  logic        SRAM_Read,
  input  logic [15:0] SRAM_DQ,
  output logic [19:0] SRAM_ADDR,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N,
  output logic [4:0]  pixelIn,
  output logic        underflow
);

  localparam int            WW     = (MAP_WORDS > 1) ? $clog2(MAP_WORDS) : 1;
  localparam logic [1:0]    PLAY   = 2'b01;
  localparam logic [4:0]    TRANSP = 5'h15;
  localparam logic [WW-1:0] LAST_W = WW'(MAP_WORDS - 1);

  typedef enum logic [1:0] {IDLE, PRIME, STREAM} state_t;
  state_t state, state_n;

  logic [WW-1:0] scroll_word, sc_word_n, rd_word;
  logic [1:0]    scroll_sub, sc_sub_n, cur_sub;
  logic [2:0]    sub_sum;
  logic [19:0]   row_addr;
  logic [14:0]   cur_word, nxt_word;
  logic          cur_vld, nxt_vld, rd_pend;
  logic          play, restart, abort, issue, adv, adv_bnd;
  logic          dq_unused;

  assign dq_unused = SRAM_DQ[15];
  assign play      = (gameState == PLAY);
  assign restart   = line_start && play;
  assign abort     = !play || frame_start;

  // Next scroll values; a same-cycle line_start loads these, so it sees the updated scroll.
  always_comb begin
    sub_sum   = {1'b0, scroll_sub} + 3'(SCROLL_STEP);
    sc_sub_n  = scroll_sub;
    sc_word_n = scroll_word;
    if (frame_start && play && ScrollEnable) begin
      if (sub_sum >= 3'd3) begin
        sc_sub_n  = 2'(sub_sum - 3'd3);
        sc_word_n = (scroll_word == LAST_W) ? '0 : scroll_word + 1'b1;
      end else begin
        sc_sub_n  = sub_sum[1:0];
      end
    end
  end

  always_comb begin
    state_n = state;
    if (restart)                                  state_n = PRIME;
    else if (abort)                               state_n = IDLE;
    else if (state == PRIME && cur_vld && nxt_vld) state_n = STREAM;
  end

  // One read in flight at most; it fills whichever buffer slot is empty when it lands.
  assign issue   = (state != IDLE) && !restart && !abort && SRAM_Read && !rd_pend
                   && (!cur_vld || !nxt_vld);
  assign adv     = (state == STREAM) && pixel_adv && cur_vld && !restart && !abort;
  assign adv_bnd = adv && (cur_sub == 2'd2);

  assign SRAM_CE_N = !issue;
  assign SRAM_OE_N = !issue;
  assign SRAM_ADDR = issue ? row_addr + 20'(rd_word) : '0;

  always_comb begin
    pixelIn = TRANSP;
    if (state == STREAM && cur_vld) begin
      case (cur_sub)
        2'd0:    pixelIn = cur_word[4:0];
        2'd1:    pixelIn = cur_word[9:5];
        2'd2:    pixelIn = cur_word[14:10];
        default: pixelIn = TRANSP;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= IDLE;
      scroll_word <= '0;
      scroll_sub  <= '0;
      row_addr    <= '0;
      rd_word     <= '0;
      cur_sub     <= '0;
      cur_word    <= '0;
      nxt_word    <= '0;
      cur_vld     <= 1'b0;
      nxt_vld     <= 1'b0;
      rd_pend     <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      state       <= state_n;
      scroll_word <= sc_word_n;
      scroll_sub  <= sc_sub_n;
      if (frame_start)             underflow <= 1'b0;
      else if (adv_bnd && !nxt_vld) underflow <= 1'b1;
      if (restart) begin
        row_addr <= 20'(BASE_ADDR) + 20'(DrawY) * 20'(MAP_WORDS);
        rd_word  <= sc_word_n;
        cur_sub  <= sc_sub_n;
        cur_vld  <= 1'b0;
        nxt_vld  <= 1'b0;
        rd_pend  <= 1'b0;
      end else if (abort) begin
        cur_vld  <= 1'b0;
        nxt_vld  <= 1'b0;
        rd_pend  <= 1'b0;
      end else begin
        rd_pend <= issue;
        if (issue) rd_word <= (rd_word == LAST_W) ? '0 : rd_word + 1'b1;
        if (adv)   cur_sub <= adv_bnd ? 2'd0 : cur_sub + 2'd1;
        if (adv_bnd) begin
          if (nxt_vld) begin
            cur_word <= nxt_word;
            nxt_vld  <= 1'b0;
          end else begin
            cur_vld  <= 1'b0;
          end
        end
        // Data landing on a starved boundary goes straight to cur: resume at its sub 0.
        if (rd_pend) begin
          if (!cur_vld || (adv_bnd && !nxt_vld)) begin
            cur_word <= SRAM_DQ[14:0];
            cur_vld  <= 1'b1;
          end else begin
            nxt_word <= SRAM_DQ[14:0];
            nxt_vld  <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sram_line_fetch.sv
// Bench for sram_line_fetch: table of scroll/row cases checked through a pixel scoreboard,
// plus hand sequences for underflow, non-PLAY, coincident frame/line start and mid-read reset.
module tb_sram_line_fetch;

  logic        Clk = 1'b0;
  logic        Reset_n, frame_start, line_start, pixel_adv, ScrollEnable, SRAM_Read;
  logic [9:0]  DrawY;
  logic [1:0]  gameState;
  logic [15:0] SRAM_DQ;
  logic [19:0] SRAM_ADDR;
  logic        SRAM_CE_N, SRAM_OE_N, underflow;
  logic [4:0]  pixelIn;

  sram_line_fetch dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_start(frame_start), .line_start(line_start),
    .pixel_adv(pixel_adv), .DrawY(DrawY), .gameState(gameState), .ScrollEnable(ScrollEnable),
    .SRAM_Read(SRAM_Read), .SRAM_DQ(SRAM_DQ), .SRAM_ADDR(SRAM_ADDR), .SRAM_CE_N(SRAM_CE_N),
    .SRAM_OE_N(SRAM_OE_N), .pixelIn(pixelIn), .underflow(underflow)
  );

  always #10 Clk = ~Clk;

  // SRAM: word a holds pixels (3a, 3a+1, 3a+2) mod 32, bit 15 toggling; words 0/1 overridden.
  logic [15:0] mem [0:1023];
  always @(posedge Clk) SRAM_DQ <= mem[SRAM_ADDR[9:0]];

  typedef struct packed {
    logic [9:0]      frames;
    logic [9:0]      y;
    logic [0:5][4:0] px;
  } vec_t;

  vec_t       vecs [6];
  logic [4:0] exp_q [$];
  int         tests = 0;
  int         fails = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge Clk); #1; end
  endtask

  task automatic do_reset();
    Reset_n = 1'b0; frame_start = 1'b0; line_start = 1'b0; pixel_adv = 1'b0;
    step(2);
    Reset_n = 1'b1;
    step(1);
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1; step(1); frame_start = 1'b0; step(1);
  endtask

  task automatic start_line(input logic [9:0] y);
    DrawY = y; line_start = 1'b1; step(1); line_start = 1'b0; step(8);
  endtask

  task automatic adv_chk(input string nm);
    logic [4:0] e;
    pixel_adv = 1'b1;
    if (exp_q.size() == 0) begin
      tests++; fails++;
      $display("FAIL %s: got %0h expected scoreboard entry (queue empty)", nm, pixelIn);
    end else begin
      e = exp_q.pop_front();
      check(nm, 32'(pixelIn), 32'(e));
    end
    step(1); pixel_adv = 1'b0; step(1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ce_seen;
    for (int a = 0; a < 1024; a++)
      mem[a] = {1'(a), 5'(3*a+2), 5'(3*a+1), 5'(3*a)};
    mem[0] = 16'h7FE0;
    mem[1] = 16'h0421;

    vecs[0] = {10'd0,   10'd0, {5'h00, 5'h1F, 5'h1F, 5'h01, 5'h01, 5'h01}};
    vecs[1] = {10'd2,   10'd0, {5'h1F, 5'h01, 5'h01, 5'h01, 5'h06, 5'h07}};
    vecs[2] = {10'd5,   10'd0, {5'h01, 5'h06, 5'h07, 5'h08, 5'h09, 5'h0A}};
    vecs[3] = {10'd0,   10'd1, {5'h1F, 5'h00, 5'h01, 5'h02, 5'h03, 5'h04}};
    vecs[4] = {10'd4,   10'd2, {5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 5'h07}};
    vecs[5] = {10'd637, 10'd0, {5'h1D, 5'h1E, 5'h00, 5'h1F, 5'h1F, 5'h01}};

    Reset_n = 1'b0; frame_start = 1'b0; line_start = 1'b0; pixel_adv = 1'b0;
    DrawY = '0; gameState = 2'b01; ScrollEnable = 1'b1; SRAM_Read = 1'b1;
    step(2);
    check("reset_ce_n",  32'(SRAM_CE_N), 32'd1);
    check("reset_oe_n",  32'(SRAM_OE_N), 32'd1);
    check("reset_addr",  32'(SRAM_ADDR), 32'd0);
    check("reset_pixel", 32'(pixelIn),   32'h15);
    check("reset_uflow", 32'(underflow), 32'd0);

    for (int v = 0; v < 6; v++) begin
      do_reset();
      gameState = 2'b01; ScrollEnable = 1'b1; SRAM_Read = 1'b1;
      repeat (int'(vecs[v].frames)) pulse_frame();
      for (int i = 0; i < 6; i++) exp_q.push_back(vecs[v].px[i]);
      start_line(vecs[v].y);
      for (int i = 0; i < 6; i++) adv_chk($sformatf("vec%0d_px%0d", v, i));
      check($sformatf("vec%0d_uflow", v), 32'(underflow), 32'd0);
    end

    // Grant withheld across the word1 -> word2 boundary.
    do_reset();
    SRAM_Read = 1'b1;
    start_line(10'd0);
    SRAM_Read = 1'b0;
    exp_q.push_back(5'h00); exp_q.push_back(5'h1F); exp_q.push_back(5'h1F);
    exp_q.push_back(5'h01); exp_q.push_back(5'h01); exp_q.push_back(5'h01);
    for (int i = 0; i < 6; i++) adv_chk($sformatf("uf_px%0d", i));
    check("uf_pixel_transp", 32'(pixelIn),   32'h15);
    check("uf_flag",         32'(underflow), 32'd1);
    step(8);
    check("uf_ce_n_no_grant", 32'(SRAM_CE_N), 32'd1);
    SRAM_Read = 1'b1;
    step(4);
    check("uf_resume_px", 32'(pixelIn), 32'h06);
    pulse_frame();
    check("uf_cleared", 32'(underflow), 32'd0);

    // START state: no reads, no scroll.
    do_reset();
    gameState = 2'b00;
    repeat (3) pulse_frame();
    DrawY = 10'd0; line_start = 1'b1; step(1); line_start = 1'b0;
    ce_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (!SRAM_CE_N) ce_seen = 1'b1;
      step(1);
    end
    check("start_no_read",  32'(ce_seen), 32'd0);
    check("start_pixel",    32'(pixelIn), 32'h15);
    gameState = 2'b01;
    exp_q.push_back(5'h00); exp_q.push_back(5'h1F);
    start_line(10'd0);
    adv_chk("start_scroll_px0");
    adv_chk("start_scroll_px1");

    // Coincident frame_start and line_start: line sees scroll 0/2.
    do_reset();
    pulse_frame();
    exp_q.push_back(5'h1F); exp_q.push_back(5'h01); exp_q.push_back(5'h01);
    DrawY = 10'd0; frame_start = 1'b1; line_start = 1'b1; step(1);
    frame_start = 1'b0; line_start = 1'b0; step(8);
    for (int i = 0; i < 3; i++) adv_chk($sformatf("coinc_px%0d", i));

    // Reset while a refetch is on the bus.
    do_reset();
    exp_q.push_back(5'h00); exp_q.push_back(5'h1F); exp_q.push_back(5'h1F);
    start_line(10'd0);
    adv_chk("rst_px0");
    adv_chk("rst_px1");
    pixel_adv = 1'b1;
    check("rst_px2", 32'(pixelIn), 32'(exp_q.pop_front()));
    step(1); pixel_adv = 1'b0;
    check("rst_read_issued", 32'(SRAM_CE_N), 32'd0);
    check("rst_read_addr",   32'(SRAM_ADDR), 32'd2);
    Reset_n = 1'b0; #1;
    check("rst_ce_n_async",  32'(SRAM_CE_N), 32'd1);
    check("rst_oe_n_async",  32'(SRAM_OE_N), 32'd1);
    check("rst_pixel_async", 32'(pixelIn),   32'h15);
    step(2);
    Reset_n = 1'b1;
    step(10);
    check("rst_idle_ce_n",  32'(SRAM_CE_N), 32'd1);
    check("rst_idle_pixel", 32'(pixelIn),   32'h15);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
